cop0_exc_seq: RTL and testbench

COP0_EXC_SEQ -- requirements
Module: cop0_exc_seq

---
 rtl/cop0_exc_seq.sv | 92 +++++++++
 tb/tb_cop0_exc_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop0_exc_seq.sv
// cop0_exc_seq: exception/interrupt entry sequencer -- reports the cause to COP0,
// stalls and flushes the pipeline, then redirects the PC to the handler vector.
module cop0_exc_seq #(
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RST_ASYNC,
  input  logic [7:0]  EXC_REQ_IN,
  input  logic        COP0_INT_IN,
  input  logic        INT_OK_IN,
  input  logic [31:0] EXC_EPC_IN,
  input  logic        EXC_BD_IN,
  input  logic [31:0] EXC_BADVA_IN,
  input  logic [1:0]  EXC_CE_IN,
  output logic        CORE_EXC_EN_OUT,
  output logic [4:0]  CORE_EXC_CODE_OUT,
  output logic [1:0]  CORE_EXC_CE_OUT,
  output logic        CORE_EXC_BD_OUT,
  output logic [31:0] CORE_EXC_EPC_OUT,
  output logic [31:0] CORE_EXC_BADVA_OUT,
  input  logic [31:0] CORE_EXC_VECTOR_IN,
  output logic        PIPE_STALL_OUT,
  output logic        PIPE_FLUSH_OUT,
  output logic        PC_LOAD_OUT,
  output logic [31:0] PC_LOAD_ADDR_OUT,
  input  logic        PC_LOAD_ACK_IN,
  output logic [15:0] EXC_CNT_OUT
);
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, REDIRECT} stateT;
  localparam logic [4:0] CODE_TAB [8] = '{5'd4, 5'd10, 5'd11, 5'd8, 5'd9, 5'd12, 5'd4, 5'd5};
  stateT state, stateNext;
  logic [3:0] flushCnt, flushCntNext;
  logic [2:0] excIdx;
  logic       anyExc, accept, hasBadVa;
  always_comb begin
    excIdx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (EXC_REQ_IN[i]) excIdx = 3'(i);
    anyExc = |EXC_REQ_IN;
    accept = (state == IDLE) && (anyExc || (COP0_INT_IN && INT_OK_IN));
    hasBadVa = anyExc && (excIdx == 3'd0 || excIdx == 3'd6 || excIdx == 3'd7);
    stateNext = state;
    flushCntNext = flushCnt;
    unique case (state)
      IDLE: stateNext = accept ? ISSUE : IDLE;
      ISSUE: begin
        stateNext = (FLUSH_CYCLES > 1) ? FLUSH : REDIRECT;
        flushCntNext = 4'(FLUSH_CYCLES - 2);
      end
      FLUSH: begin
        stateNext = (flushCnt == 4'd0) ? REDIRECT : FLUSH;
        flushCntNext = flushCnt - 4'd1;
      end
      REDIRECT: stateNext = PC_LOAD_ACK_IN ? IDLE : REDIRECT;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state              <= IDLE;
      flushCnt           <= 4'd0;
      CORE_EXC_EN_OUT    <= 1'b0;
      CORE_EXC_CODE_OUT  <= 5'd0;
      CORE_EXC_CE_OUT    <= 2'b00;
      CORE_EXC_BD_OUT    <= 1'b0;
      CORE_EXC_EPC_OUT   <= 32'h0;
      CORE_EXC_BADVA_OUT <= 32'h0;
      PIPE_STALL_OUT     <= 1'b0;
      PIPE_FLUSH_OUT     <= 1'b0;
      PC_LOAD_OUT        <= 1'b0;
      PC_LOAD_ADDR_OUT   <= 32'h0;
      EXC_CNT_OUT        <= 16'h0;
    end else begin
      state    <= stateNext;
      flushCnt <= flushCntNext;
      CORE_EXC_EN_OUT <= (stateNext == ISSUE);
      PIPE_FLUSH_OUT  <= (stateNext == ISSUE) || (stateNext == FLUSH);
      PIPE_STALL_OUT  <= (stateNext != IDLE);
      PC_LOAD_OUT     <= (stateNext == REDIRECT);
      // Cause context and vector are frozen at acceptance so the handler sees a stable report
      if (accept) begin
        CORE_EXC_CODE_OUT  <= anyExc ? CODE_TAB[excIdx] : 5'd0;
        CORE_EXC_CE_OUT    <= (anyExc && excIdx == 3'd2) ? EXC_CE_IN : 2'b00;
        CORE_EXC_BD_OUT    <= EXC_BD_IN;
        CORE_EXC_EPC_OUT   <= EXC_EPC_IN;
        CORE_EXC_BADVA_OUT <= hasBadVa ? EXC_BADVA_IN : 32'h0;
        PC_LOAD_ADDR_OUT   <= CORE_EXC_VECTOR_IN;
        EXC_CNT_OUT        <= (EXC_CNT_OUT == 16'hFFFF) ? EXC_CNT_OUT : EXC_CNT_OUT + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_cop0_exc_seq.sv
// tb_cop0_exc_seq: directed scenarios plus randomized traffic against a cycle-age model.
module tb_cop0_exc_seq;
  localparam int FC = 3;
  logic CLK = 1'b0, RST_ASYNC = 1'b1;
  logic [7:0] req;
  logic intr, intOk, bd, ack;
  logic [31:0] epc, badva, vec;
  logic [1:0] ce;
  logic en, bdO, stall, flush, pcLoad;
  logic [4:0] code;
  logic [1:0] ceO;
  logic [31:0] epcO, badvaO, pcAddr;
  logic [15:0] cnt;
  logic en1, bdO1, stall1, flush1, pcLoad1;
  logic [4:0] code1;
  logic [1:0] ceO1;
  logic [31:0] epcO1, badvaO1, pcAddr1;
  logic [15:0] cnt1;
  int checks = 0, failures = 0;
  int codeTab [8] = '{4, 10, 11, 8, 9, 12, 4, 5};

  always #5 CLK = ~CLK;

  cop0_exc_seq #(.FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .RST_ASYNC(RST_ASYNC), .EXC_REQ_IN(req), .COP0_INT_IN(intr), .INT_OK_IN(intOk),
    .EXC_EPC_IN(epc), .EXC_BD_IN(bd), .EXC_BADVA_IN(badva), .EXC_CE_IN(ce),
    .CORE_EXC_EN_OUT(en), .CORE_EXC_CODE_OUT(code), .CORE_EXC_CE_OUT(ceO), .CORE_EXC_BD_OUT(bdO),
    .CORE_EXC_EPC_OUT(epcO), .CORE_EXC_BADVA_OUT(badvaO), .CORE_EXC_VECTOR_IN(vec),
    .PIPE_STALL_OUT(stall), .PIPE_FLUSH_OUT(flush), .PC_LOAD_OUT(pcLoad), .PC_LOAD_ADDR_OUT(pcAddr),
    .PC_LOAD_ACK_IN(ack), .EXC_CNT_OUT(cnt));

  cop0_exc_seq #(.FLUSH_CYCLES(1)) dut1 (
    .CLK(CLK), .RST_ASYNC(RST_ASYNC), .EXC_REQ_IN(req), .COP0_INT_IN(intr), .INT_OK_IN(intOk),
    .EXC_EPC_IN(epc), .EXC_BD_IN(bd), .EXC_BADVA_IN(badva), .EXC_CE_IN(ce),
    .CORE_EXC_EN_OUT(en1), .CORE_EXC_CODE_OUT(code1), .CORE_EXC_CE_OUT(ceO1), .CORE_EXC_BD_OUT(bdO1),
    .CORE_EXC_EPC_OUT(epcO1), .CORE_EXC_BADVA_OUT(badvaO1), .CORE_EXC_VECTOR_IN(vec),
    .PIPE_STALL_OUT(stall1), .PIPE_FLUSH_OUT(flush1), .PC_LOAD_OUT(pcLoad1), .PC_LOAD_ADDR_OUT(pcAddr1),
    .PC_LOAD_ACK_IN(ack), .EXC_CNT_OUT(cnt1));

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    req = 8'h0; intr = 1'b0; intOk = 1'b0; bd = 1'b0; ack = 1'b0;
    epc = 32'h0; badva = 32'h0; vec = 32'h0; ce = 2'b00;
  endtask

  task automatic do_reset;
    clear_inputs();
    RST_ASYNC = 1'b1;
    tick();
    tick();
    RST_ASYNC = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    req = 8'hFF; intr = 1'b1; intOk = 1'b1; ack = 1'b1;
    tick();
    checks++;
    if ({en, code, ceO, bdO, epcO, badvaO, stall, flush, pcLoad, pcAddr, cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: en=%b stall=%b pcLoad=%b cnt=%0h want all zero", en, stall, pcLoad, cnt);
    end
    checks++;
    if ({en1, stall1, pcLoad1, cnt1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_fc1: en=%b stall=%b pcLoad=%b cnt=%0h want all zero", en1, stall1, pcLoad1, cnt1);
    end
    clear_inputs();
    RST_ASYNC = 1'b0;
    tick();
    checks++;
    if (stall !== 1'b0 || en !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: stall=%b en=%b want 0 0", stall, en);
    end
  endtask

  task automatic test_syscall;
    logic [3:0] exp;
    do_reset();
    req = 8'h08; epc = 32'h100; vec = 32'h80000080; badva = 32'h5555; ce = 2'b11; bd = 1'b1;
    tick();
    clear_inputs();
    vec = 32'h11110000;
    checks++;
    if (code !== 5'd8 || epcO !== 32'h100 || badvaO !== 32'h0 || ceO !== 2'b00 || bdO !== 1'b1 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL syscall_ctx: code=%0d epc=%h badva=%h ce=%b bd=%b cnt=%0d want 8 100 0 0 1 1", code, epcO, badvaO, ceO, bdO, cnt);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      exp = {1'(k == 0), 1'(k < 3), 1'b1, 1'(k == 3)};
      checks++;
      if ({en, flush, stall, pcLoad} !== exp) begin
        failures++;
        $display("FAIL syscall_seq[%0d]: en/flush/stall/pcLoad=%b want %b", k, {en, flush, stall, pcLoad}, exp);
      end
    end
    checks++;
    if (pcAddr !== 32'h80000080) begin
      failures++;
      $display("FAIL syscall_vector: got %h want 80000080", pcAddr);
    end
    tick();
    ack = 1'b1;
    checks++;
    if (pcLoad !== 1'b1) begin
      failures++;
      $display("FAIL syscall_hold: pcLoad=%b want 1", pcLoad);
    end
    tick();
    ack = 1'b0;
    checks++;
    if (pcLoad !== 1'b0 || stall !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL syscall_done: pcLoad=%b stall=%b cnt=%0d want 0 0 1", pcLoad, stall, cnt);
    end
  endtask

  task automatic test_priority;
    do_reset();
    req = 8'hC2; intr = 1'b1; intOk = 1'b1; badva = 32'h12345678;
    tick();
    clear_inputs();
    checks++;
    if (en !== 1'b1 || code !== 5'd10 || badvaO !== 32'h0) begin
      failures++;
      $display("FAIL priority_ri: en=%b code=%0d badva=%h want 1 10 0", en, code, badvaO);
    end
    do_reset();
    req = 8'h80; badva = 32'hDEAD0003; ce = 2'b01;
    tick();
    clear_inputs();
    checks++;
    if (code !== 5'd5 || badvaO !== 32'hDEAD0003 || ceO !== 2'b00) begin
      failures++;
      $display("FAIL priority_ades: code=%0d badva=%h ce=%b want 5 dead0003 0", code, badvaO, ceO);
    end
  endtask

  task automatic test_interrupt;
    do_reset();
    intr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (stall !== 1'b0 || en !== 1'b0) begin
        failures++;
        $display("FAIL int_gated[%0d]: stall=%b en=%b want 0 0", k, stall, en);
      end
    end
    intOk = 1'b1;
    tick();
    intr = 1'b0; intOk = 1'b0;
    checks++;
    if (en !== 1'b1 || code !== 5'd0) begin
      failures++;
      $display("FAIL int_taken: en=%b code=%0d want 1 0", en, code);
    end
    tick();
    tick();
    tick();
    req = 8'h02;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (pcLoad !== 1'b1 || en !== 1'b0) begin
        failures++;
        $display("FAIL int_redirect_hold[%0d]: pcLoad=%b en=%b want 1 0", k, pcLoad, en);
      end
      if (k < 4) tick();
    end
    ack = 1'b1;
    tick();
    req = 8'h0; ack = 1'b0;
    tick();
    checks++;
    if (pcLoad !== 1'b0 || stall !== 1'b0 || en !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL int_ignored_req: pcLoad=%b stall=%b en=%b cnt=%0d want 0 0 0 1", pcLoad, stall, en, cnt);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    req = 8'h20; epc = 32'hCAFE0000;
    tick();
    req = 8'h0;
    tick();
    checks++;
    if (flush !== 1'b1 || stall !== 1'b1 || en !== 1'b0) begin
      failures++;
      $display("FAIL areset_preflush: flush=%b stall=%b en=%b want 1 1 0", flush, stall, en);
    end
    #2 RST_ASYNC = 1'b1;
    #1;
    checks++;
    if ({en, code, ceO, bdO, epcO, badvaO, stall, flush, pcLoad, pcAddr, cnt} !== '0) begin
      failures++;
      $display("FAIL areset_immediate: flush=%b stall=%b epc=%h cnt=%0d want all zero", flush, stall, epcO, cnt);
    end
    #2 RST_ASYNC = 1'b0;
    ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (pcLoad !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL areset_abandon[%0d]: pcLoad=%b stall=%b want 0 0", k, pcLoad, stall);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_flush1;
    do_reset();
    req = 8'h04; ce = 2'b10; vec = 32'hBFC00380;
    tick();
    clear_inputs();
    checks++;
    if ({en1, flush1, pcLoad1} !== 3'b110 || code1 !== 5'd11 || ceO1 !== 2'b10) begin
      failures++;
      $display("FAIL fc1_issue: en/flush/pcLoad=%b code=%0d ce=%b want 110 11 10", {en1, flush1, pcLoad1}, code1, ceO1);
    end
    tick();
    checks++;
    if ({en1, flush1, pcLoad1} !== 3'b001 || pcAddr1 !== 32'hBFC00380) begin
      failures++;
      $display("FAIL fc1_redirect: en/flush/pcLoad=%b addr=%h want 001 bfc00380", {en1, flush1, pcLoad1}, pcAddr1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (pcLoad1 !== 1'b0 || stall1 !== 1'b0) begin
      failures++;
      $display("FAIL fc1_done: pcLoad=%b stall=%b want 0 0", pcLoad1, stall1);
    end
  endtask

  // Model tracks only "cycles since acceptance"; output phases follow from that age.
  task automatic test_random;
    bit busy = 0;
    int age = 0, idx;
    logic [4:0] mCode = '0;
    logic [1:0] mCe = '0;
    logic mBd = 0;
    logic [31:0] mEpc = '0, mBadva = '0, mVec = '0;
    logic [15:0] mCnt = '0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      intr = ($urandom_range(0, 3) == 0); intOk = 1'($urandom);
      bd = 1'($urandom); ce = 2'($urandom); ack = ($urandom_range(0, 2) == 0);
      epc = $urandom; badva = $urandom; vec = $urandom;
      if (!busy) begin
        if (req != 0 || (intr && intOk)) begin
          idx = -1;
          for (int b = 7; b >= 0; b--) if (req[b]) idx = b;
          busy = 1; age = 1;
          mCode = (idx < 0) ? 5'd0 : 5'(codeTab[idx]);
          mBadva = (idx == 0 || idx == 6 || idx == 7) ? badva : 32'h0;
          mCe = (idx == 2) ? ce : 2'b00;
          mBd = bd; mEpc = epc; mVec = vec;
          mCnt = (mCnt == 16'hFFFF) ? mCnt : mCnt + 16'd1;
        end
      end else if (age > FC && ack) busy = 0;
      else age++;
      tick();
      checks++;
      if ({en, flush, stall, pcLoad} !== {1'(busy && age == 1), 1'(busy && age <= FC), 1'(busy), 1'(busy && age > FC)}) begin
        failures++;
        $display("FAIL rand_ctrl@%0d: en/flush/stall/pcLoad=%b want %b", c, {en, flush, stall, pcLoad},
                 {1'(busy && age == 1), 1'(busy && age <= FC), 1'(busy), 1'(busy && age > FC)});
      end
      checks++;
      if ({code, ceO, bdO, epcO, badvaO, pcAddr, cnt} !== {mCode, mCe, mBd, mEpc, mBadva, mVec, mCnt}) begin
        failures++;
        $display("FAIL rand_ctx@%0d: code=%0d ce=%b bd=%b epc=%h badva=%h addr=%h cnt=%0d want %0d %b %b %h %h %h %0d",
                 c, code, ceO, bdO, epcO, badvaO, pcAddr, cnt, mCode, mCe, mBd, mEpc, mBadva, mVec, mCnt);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_syscall();
    test_priority();
    test_interrupt();
    test_async_reset();
    test_flush1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
